// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arbiter
//  Description : Shares one APB master port between NUM_REQ local requesters.
//                Round-robin arbitration with a single transfer in flight.
//                The block sequences the APB IDLE/SETUP/ACCESS phases and
//                returns the response to the granted requester. A transfer
//                that stalls in ACCESS for TIMEOUT cycles is aborted with an
//                error response.
//  Ports       : PCLK, PRESET      clock / synchronous active-high reset
//                req_*             packed per-requester request fields
//                                  (requester i at [i*W +: W])
//                req_ready         one-hot accept pulse (combinational)
//                rsp_valid         one-hot response pulse to the owner
//                rsp_rdata/rsp_err response payload
//                P*                APB master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PWDATA,
  output logic [(DATA_W/8)-1:0]         PSTRB,
  output logic [2:0]                    PPROT,
  input  logic                          PREADY,
  input  logic [DATA_W-1:0]             PRDATA,
  input  logic                          PSLVERR
);

  localparam int c_SW    = DATA_W / 8;
  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_ROT_W = c_PTR_W + 1;
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_ROT_W-1:0] c_NUM     = c_ROT_W'(NUM_REQ);
  localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   r_owner;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_any;
  logic                 w_found;
  logic [c_ROT_W-1:0]   w_rot;
  logic [c_PTR_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic                 w_sel_write;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic [c_SW-1:0]      w_sel_strb;
  logic [2:0]           w_sel_prot;
  logic                 w_timeout;

  // Round-robin scan: first pending requester at or above the pointer,
  // wrapping past NUM_REQ-1 back to 0.
  always_comb begin : p_arb
    w_any       = |req_valid;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_rot       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot = {1'b0, r_ptr} + c_ROT_W'(i);
      if (w_rot >= c_NUM) begin
        w_rot = w_rot - c_NUM;
      end
      if (!w_found && req_valid[w_rot[c_PTR_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_rot[c_PTR_W-1:0];
      end
    end
  end

  // Field mux for the granted requester and one-hot decodes.
  always_comb begin : p_sel
    w_grant_oh  = '0;
    w_owner_oh  = '0;
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    w_sel_prot  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant_idx == c_PTR_W'(j)) begin
        w_grant_oh[j] = 1'b1;
        w_sel_addr    = req_addr[j*ADDR_W +: ADDR_W];
        w_sel_write   = req_write[j];
        w_sel_wdata   = req_wdata[j*DATA_W +: DATA_W];
        w_sel_strb    = req_strb[j*c_SW +: c_SW];
        w_sel_prot    = req_prot[j*3 +: 3];
      end
      if (r_owner == c_PTR_W'(j)) begin
        w_owner_oh[j] = 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_cnt == c_TO_LAST);

  always_ff @(posedge PCLK) begin : p_state
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_SETUP;
          req_ready   = w_grant_oh;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // No accept is offered while the block is being reset.
    if (PRESET) begin
      req_ready = '0;
    end
  end

  assign PSEL    = (r_state != S_IDLE);
  assign PENABLE = (r_state == S_ACCESS);

  always_ff @(posedge PCLK) begin : p_data
    if (PRESET) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_owner <= w_grant_idx;
            r_ptr   <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + c_PTR_W'(1);
            PADDR   <= w_sel_addr;
            PWRITE  <= w_sel_write;
            PWDATA  <= w_sel_wdata;
            PSTRB   <= w_sel_write ? w_sel_strb : '0;
            PPROT   <= w_sel_prot;
          end
        end
        S_ACCESS: begin
          if (PREADY) begin
            r_cnt     <= '0;
            rsp_valid <= w_owner_oh;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
          end else if (w_timeout) begin
            r_cnt     <= '0;
            rsp_valid <= w_owner_oh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_arbiter
//  Description : Directed self-checking bench for apb_master_arbiter
//                (NUM_REQ=2, 32-bit address/data, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_tests;
  int n_fail;

  apb_master_arbiter #(
    .NUM_REQ(2),
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) u_dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .req_prot (req_prot),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PPROT    (PPROT),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_addr[i*32 +: 32] = a;
    req_write[i]         = w;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]   = s;
    req_prot[i*3 +: 3]   = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [1:0]  exp_g [4];
  logic [31:0] exp_a [4];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    PRESET    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{32'h100, 32'h104, 32'h100, 32'h104};

    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel",    PSEL,      1'b0);
    chk("rst_penable", PENABLE,   1'b0);
    chk("rst_paddr",   PADDR,     32'h0);
    chk("rst_rspv",    rsp_valid, 2'b00);
    chk("rst_ready",   req_ready, 2'b00);
    PRESET = 1'b0;

    // 1: zero-wait write from requester 0
    set_req(0, 32'h10, 1'b1, 32'hA5A5A5A5, 4'hF, 3'd2);
    req_valid = 2'b01;
    PREADY    = 1'b1;
    #1;
    chk("t1_ready_c0", req_ready, 2'b01);
    chk("t1_psel_c0",  PSEL,      1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t1_psel_c1",   PSEL,    1'b1);
    chk("t1_pen_c1",    PENABLE, 1'b0);
    chk("t1_paddr",     PADDR,   32'h10);
    chk("t1_pwdata",    PWDATA,  32'hA5A5A5A5);
    chk("t1_pstrb",     PSTRB,   4'hF);
    chk("t1_pwrite",    PWRITE,  1'b1);
    chk("t1_pprot",     PPROT,   3'd2);
    chk("t1_ready_c1",  req_ready, 2'b00);
    tick();
    #1;
    chk("t1_psel_c2", PSEL,    1'b1);
    chk("t1_pen_c2",  PENABLE, 1'b1);
    tick();
    #1;
    chk("t1_rspv_c3", rsp_valid, 2'b01);
    chk("t1_err_c3",  rsp_err,   1'b0);
    chk("t1_rdat_c3", rsp_rdata, 32'h0);
    chk("t1_psel_c3", PSEL,      1'b0);
    chk("t1_pen_c3",  PENABLE,   1'b0);

    // 2: read from requester 1 with three wait states
    set_req(1, 32'h20, 1'b0, 32'hFFFFFFFF, 4'hF, 3'd0);
    req_valid = 2'b10;
    PREADY    = 1'b0;
    PRDATA    = 32'hBAD0BAD0;
    #1;
    chk("t2_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t2_paddr_setup", PADDR,  32'h20);
    chk("t2_pstrb",       PSTRB,  4'h0);
    chk("t2_pwrite",      PWRITE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("t2_paddr_wait", PADDR,     32'h20);
      chk("t2_pen_wait",   PENABLE,   1'b1);
      chk("t2_rspv_wait",  rsp_valid, 2'b00);
    end
    tick();
    PREADY = 1'b1;
    PRDATA = 32'h1234;
    #1;
    chk("t2_paddr_done", PADDR,   32'h20);
    chk("t2_pen_done",   PENABLE, 1'b1);
    tick();
    PREADY = 1'b0;
    #1;
    chk("t2_rspv",  rsp_valid, 2'b10);
    chk("t2_rdata", rsp_rdata, 32'h1234);
    chk("t2_err",   rsp_err,   1'b0);
    chk("t2_pen",   PENABLE,   1'b0);

    // 3: both requesters continuously pending, four zero-wait writes
    set_req(0, 32'h100, 1'b1, 32'h11111111, 4'hF, 3'd0);
    set_req(1, 32'h104, 1'b1, 32'h22222222, 4'hF, 3'd0);
    req_valid = 2'b11;
    PREADY    = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("t3_grant", req_ready, exp_g[t]);
      if (t > 0) chk("t3_rspv_prev", rsp_valid, exp_g[t-1]);
      tick();
      if (t == 3) req_valid = 2'b00;
      #1;
      chk("t3_paddr", PADDR,   exp_a[t]);
      chk("t3_pen0",  PENABLE, 1'b0);
      tick();
      #1;
      chk("t3_pen1", PENABLE, 1'b1);
      tick();
    end
    #1;
    chk("t3_rspv_last",  rsp_valid, 2'b10);
    chk("t3_ready_idle", req_ready, 2'b00);
    chk("t3_psel_idle",  PSEL,      1'b0);

    // 4: read that never completes, aborted after 16 ACCESS cycles
    set_req(0, 32'h40, 1'b0, 32'h0, 4'h0, 3'd0);
    req_valid = 2'b01;
    PREADY    = 1'b0;
    PRDATA    = 32'hDEADBEEF;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 16; k++) begin
      tick();
      #1;
      chk("t4_pen_wait",  PENABLE,   1'b1);
      chk("t4_rspv_wait", rsp_valid, 2'b00);
    end
    tick();
    #1;
    chk("t4_rspv",  rsp_valid, 2'b01);
    chk("t4_err",   rsp_err,   1'b1);
    chk("t4_rdata", rsp_rdata, 32'h0);
    chk("t4_pen",   PENABLE,   1'b0);

    // 5: write with slave error, followed by a normal transfer
    set_req(1, 32'h44, 1'b1, 32'hCAFEF00D, 4'h3, 3'd1);
    req_valid = 2'b10;
    PREADY    = 1'b1;
    PSLVERR   = 1'b1;
    #1;
    chk("t5_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t5_pstrb", PSTRB, 4'h3);
    tick();
    tick();
    PSLVERR = 1'b0;
    set_req(0, 32'h50, 1'b1, 32'h55555555, 4'hF, 3'd0);
    req_valid = 2'b01;
    #1;
    chk("t5_rspv",    rsp_valid, 2'b10);
    chk("t5_err",     rsp_err,   1'b1);
    chk("t5_rdata",   rsp_rdata, 32'h0);
    chk("t5_ready2",  req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t5_paddr2", PADDR, 32'h50);
    tick();
    tick();
    #1;
    chk("t5_rspv2", rsp_valid, 2'b01);
    chk("t5_err2",  rsp_err,   1'b0);

    // 6: reset asserted mid-ACCESS
    set_req(0, 32'h60, 1'b1, 32'h0000600D, 4'hF, 3'd3);
    req_valid = 2'b01;
    PREADY    = 1'b0;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    PRESET = 1'b1;
    #1;
    chk("t6_pen_access", PENABLE, 1'b1);
    tick();
    chk("t6_psel",   PSEL,      1'b0);
    chk("t6_pen",    PENABLE,   1'b0);
    chk("t6_paddr",  PADDR,     32'h0);
    chk("t6_pwdata", PWDATA,    32'h0);
    chk("t6_pstrb",  PSTRB,     4'h0);
    chk("t6_pprot",  PPROT,     3'd0);
    chk("t6_pwrite", PWRITE,    1'b0);
    chk("t6_rspv",   rsp_valid, 2'b00);
    PRESET = 1'b0;
    set_req(1, 32'h70, 1'b1, 32'h77777777, 4'hF, 3'd0);
    req_valid = 2'b11;
    PREADY    = 1'b1;
    #1;
    chk("t6_ptr_grant", req_ready, 2'b01);
    chk("t6_rspv_post", rsp_valid, 2'b00);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    chk("t6_rspv_new", rsp_valid, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
